// File: rtl/envelope_vca.sv
// Attack/sustain/release envelope driving a PWM gate on a square oscillator.
// Level moves one LSB per rate step; pwmout lags osc_in by one clock; no backpressure.
module envelope_vca #(
  parameter int TICK_DIV    = 256,
  parameter int LEVEL_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   gate,
  input  logic                   osc_in,
  input  logic [3:0]             attack_rate,
  input  logic [3:0]             release_rate,
  output logic [LEVEL_WIDTH-1:0] level,
  output logic                   busy,
  output logic                   pwmout
);

  localparam int TW = $clog2(TICK_DIV);
  localparam logic [TW-1:0]          TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [LEVEL_WIDTH-1:0] LVL_MAX   = '1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ATTACK,
    ST_SUSTAIN,
    ST_RELEASE
  } state_t;

  state_t                 state_q, state_d;
  logic [TW-1:0]          tick_cnt_q, tick_cnt_d;
  logic [3:0]             rate_cnt_q, rate_cnt_d;
  logic [LEVEL_WIDTH-1:0] level_q, level_d;
  logic [LEVEL_WIDTH-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [LEVEL_WIDTH-1:0] pwm_level_q, pwm_level_d;
  logic                   pwmout_q, pwmout_d;

  logic       tick;
  logic       rate_hit;
  logic [3:0] active_rate;

  always_comb begin
    tick        = (tick_cnt_q == TICK_LAST);
    tick_cnt_d  = tick ? '0 : tick_cnt_q + 1'b1;
    active_rate = (state_q == ST_RELEASE) ? release_rate : attack_rate;
    rate_hit    = tick && (rate_cnt_q == active_rate);

    state_d = state_q;
    level_d = level_q;
    // A gate transition takes priority over a pending level step.
    case (state_q)
      ST_IDLE: begin
        level_d = '0;
        if (gate) state_d = ST_ATTACK;
      end
      ST_ATTACK: begin
        if (!gate) begin
          state_d = ST_RELEASE;
        end else if (rate_hit) begin
          level_d = (level_q == LVL_MAX) ? LVL_MAX : level_q + 1'b1;
          if (level_d == LVL_MAX) state_d = ST_SUSTAIN;
        end
      end
      ST_SUSTAIN: begin
        level_d = LVL_MAX;
        if (!gate) state_d = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (gate) begin
          state_d = ST_ATTACK;
        end else if (rate_hit) begin
          level_d = (level_q == '0) ? '0 : level_q - 1'b1;
          if (level_d == '0) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    rate_cnt_d = rate_cnt_q;
    if ((state_d != state_q) || (state_q == ST_IDLE) || (state_q == ST_SUSTAIN)) begin
      rate_cnt_d = '0;
    end else if (rate_hit) begin
      rate_cnt_d = '0;
    end else if (tick) begin
      rate_cnt_d = rate_cnt_q + 4'd1;
    end

    // Shadow level only changes at the PWM period boundary to avoid mid-period glitches.
    pwm_cnt_d   = pwm_cnt_q + 1'b1;
    pwm_level_d = (pwm_cnt_q == LVL_MAX) ? level_q : pwm_level_q;
    pwmout_d    = osc_in && (pwm_cnt_q < pwm_level_q);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      tick_cnt_q  <= '0;
      rate_cnt_q  <= '0;
      level_q     <= '0;
      pwm_cnt_q   <= '0;
      pwm_level_q <= '0;
      pwmout_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      rate_cnt_q  <= rate_cnt_d;
      level_q     <= level_d;
      pwm_cnt_q   <= pwm_cnt_d;
      pwm_level_q <= pwm_level_d;
      pwmout_q    <= pwmout_d;
    end
  end

  assign level  = level_q;
  assign busy   = (state_q != ST_IDLE);
  assign pwmout = pwmout_q;

endmodule

// File: tb/tb_envelope_vca.sv
// Bench for envelope_vca: per-cycle comparison against a behavioural envelope/PWM model,
// plus directed scenarios with hand-derived expectations.
module tb_envelope_vca;
  localparam int TD = 4;
  localparam int S_IDLE = 0, S_ATT = 1, S_SUS = 2, S_REL = 3;

  logic       clk = 1'b0;
  logic       rst, gate, osc_in;
  logic [3:0] attack_rate, release_rate;
  logic [7:0] level;
  logic       busy, pwmout;

  envelope_vca #(.TICK_DIV(TD), .LEVEL_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .gate(gate), .osc_in(osc_in),
    .attack_rate(attack_rate), .release_rate(release_rate),
    .level(level), .busy(busy), .pwmout(pwmout)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  bit d_rst, d_gate, d_osc;
  int d_ar, d_rr;

  // Model: clocks since reset, envelope phase, level, ticks accumulated toward a step, PWM.
  int m_n, m_state, m_level, m_rc, m_pcnt, m_plev;
  bit m_pwm;

  task automatic check_eq(input string name, input logic [31:0] act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 20) $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      if (errors <= 20) $display("FAIL %s: got %0d, want %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired, level now %0d", name, m_level);
  endtask

  task automatic model_step();
    int  nst, nlev, rate;
    bit  tick, hit;
    if (!d_rst) begin
      m_n = 0; m_state = S_IDLE; m_level = 0; m_rc = 0;
      m_pcnt = 0; m_plev = 0; m_pwm = 1'b0;
      return;
    end
    m_pwm = d_osc && (m_pcnt < m_plev);
    if (m_pcnt == 255) m_plev = m_level;
    m_pcnt = (m_pcnt + 1) % 256;

    tick = ((m_n % TD) == TD - 1);
    m_n++;
    rate = (m_state == S_REL) ? d_rr : d_ar;
    hit  = tick && (m_rc == rate);
    nst  = m_state;
    nlev = m_level;
    if (m_state == S_IDLE) begin
      if (d_gate) nst = S_ATT;
    end else if (m_state == S_ATT) begin
      if (!d_gate) nst = S_REL;
      else if (hit) begin
        nlev = (m_level + 1 > 255) ? 255 : m_level + 1;
        if (nlev == 255) nst = S_SUS;
      end
    end else if (m_state == S_SUS) begin
      if (!d_gate) nst = S_REL;
    end else begin
      if (d_gate) nst = S_ATT;
      else if (hit) begin
        nlev = (m_level - 1 < 0) ? 0 : m_level - 1;
        if (nlev == 0) nst = S_IDLE;
      end
    end
    if (nst != m_state || m_state == S_IDLE || m_state == S_SUS || hit) m_rc = 0;
    else if (tick) m_rc = (m_rc + 1) % 16;
    m_state = nst;
    m_level = nlev;
  endtask

  // Drive inputs, advance model across the coming edge, compare on the falling edge.
  task automatic cyc();
    rst = d_rst; gate = d_gate; osc_in = d_osc;
    attack_rate = 4'(d_ar); release_rate = 4'(d_rr);
    model_step();
    @(negedge clk);
    check_eq("level", level, m_level);
    check_eq("busy", busy, (m_state != S_IDLE) ? 1 : 0);
    check_eq("pwmout", pwmout, m_pwm ? 1 : 0);
  endtask

  task automatic run_until_level(input int target, input int bound, input string name);
    int k = 0;
    while (m_level != target && k < bound) begin
      cyc();
      k++;
    end
    if (m_level != target) timeout_fail(name);
  endtask

  initial begin
    int cnt, hi, minlev, lv;

    d_rst = 0; d_gate = 0; d_osc = 1; d_ar = 0; d_rr = 1;
    repeat (3) cyc();
    check_eq("reset_level", level, 0);
    check_eq("reset_busy", busy, 0);
    check_eq("reset_pwmout", pwmout, 0);

    // Full attack with rate 0 at TICK_DIV=4.
    d_rst = 1;
    cyc();
    d_gate = 1;
    cyc();
    check_eq("attack_busy_next", busy, 1);
    check_eq("attack_level_start", level, 0);
    cnt = 0;
    while (level !== 8'd255 && cnt < 1100) begin cyc(); cnt++; end
    check_range("attack_cycles", cnt, 1015, 1022);
    repeat (20) cyc();
    check_eq("sustain_level", level, 255);
    check_eq("sustain_busy", busy, 1);

    // Release at rate 1: one step per 8 clocks.
    d_gate = 0;
    cyc();
    cnt = 0;
    while (level !== 8'd0 && cnt < 2200) begin cyc(); cnt++; end
    check_range("release_cycles", cnt, 2034, 2042);
    check_eq("release_idle_busy", busy, 0);

    // Release at 100, re-attack at 60: must resume from 60.
    d_ar = 0; d_rr = 0; d_gate = 1;
    run_until_level(100, 600, "wait_100");
    d_gate = 0;
    cyc();
    check_eq("gate_fall_at_100", level, 100);
    run_until_level(60, 400, "wait_60");
    d_gate = 1;
    minlev = 255;
    for (int i = 0; i < 200; i++) begin
      cyc();
      if (int'(level) < minlev) minlev = int'(level);
    end
    check_eq("reattack_min_level", minlev, 60);
    check_range("reattack_climbs", int'(level), 105, 112);

    // Gate fall coinciding with an attack step: level holds, state RELEASE.
    cnt = 0;
    while (!(m_state == S_ATT && (m_n % TD) == TD - 1) && cnt < 16) begin cyc(); cnt++; end
    if (!(m_state == S_ATT && (m_n % TD) == TD - 1)) timeout_fail("wait_step_edge");
    lv = m_level;
    d_gate = 0;
    cyc();
    check_eq("gate_vs_step_level", level, lv);
    check_eq("gate_vs_step_busy", busy, 1);
    cyc();
    check_eq("gate_vs_step_release", level, lv);

    // Freeze level at 64 by toggling gate every cycle, then measure PWM duty.
    run_until_level(64, 600, "wait_64");
    d_osc = 1;
    for (int i = 0; i < 512; i++) begin d_gate = ~d_gate; cyc(); end
    for (int w = 0; w < 2; w++) begin
      hi = 0;
      for (int i = 0; i < 256; i++) begin
        d_gate = ~d_gate;
        cyc();
        if (pwmout === 1'b1) hi++;
      end
      check_eq("pwm_duty_64", hi, 64);
    end
    check_eq("frozen_level", level, 64);

    // Reset mid-release at 150 with gate high.
    d_gate = 1;
    run_until_level(255, 1200, "wait_255");
    d_gate = 0;
    run_until_level(150, 600, "wait_150");
    d_rst = 0; d_gate = 1;
    cyc();
    check_eq("rst_level", level, 0);
    check_eq("rst_pwmout", pwmout, 0);
    check_eq("rst_busy", busy, 0);
    d_rst = 1;
    cyc();
    check_eq("post_rst_busy", busy, 1);
    check_eq("post_rst_level", level, 0);
    repeat (40) cyc();
    check_range("post_rst_climb", int'(level), 8, 11);

    // Randomised traffic against the model.
    for (int i = 0; i < 20000; i++) begin
      d_rst = ($urandom_range(0, 2999) != 0);
      if ($urandom_range(0, 63) == 0) d_gate = ~d_gate;
      d_osc = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 299) == 0) d_ar = $urandom_range(0, 1) ? $urandom_range(0, 3) : $urandom_range(0, 15);
      if ($urandom_range(0, 299) == 0) d_rr = $urandom_range(0, 1) ? $urandom_range(0, 3) : $urandom_range(0, 15);
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
